multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Main control unit for the multicycle MIPS core. It replaces the single-cycle combinational decoder inside `mips` once the core moves to a shared instruction/data memory. The block sequences each instruction through a Moore FSM (fetch, decode, execute, memory, writeback) and drives all datapath enables and multiplexer selects. A combinational ALU decoder maps the opcode class and funct field to the ALU operation.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge
- `reset`  in  1  asynchronous, active-high; forces FSM to FETCH immediately
- `op`  in  6  instr[31:26] from the instruction register
- `funct`  in  6  instr[5:0] from the instruction register
- `zero`  in  1  ALU zero flag, same cycle
- `iord`  out  1  memory address select: 0 = PC, 1 = ALUOut
- `memwrite`  out  1  shared memory write enable
- `irwrite`  out  1  instruction register load
- `regdst`  out  1  destination register: 0 = rt, 1 = rd
- `memtoreg`  out  1  writeback source: 0 = ALUOut, 1 = Data
- `regwrite`  out  1  register file write enable
- `alusrca`  out  1  ALU operand A: 0 = PC, 1 = A reg
- `alusrcb`  out  2  ALU operand B: 00 B reg, 01 const 4, 10 SignImm, 11 SignImm<<2
- `pcsrc`  out  2  next PC: 00 ALUResult, 01 ALUOut, 10 jump target
- `alucontrol`  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- `pcen`  out  1  PC load: pcwrite | (beq & zero) | (bne & ~zero)
- `illegal`  out  1  one-cycle pulse in DECODE for an unsupported opcode

## Operation
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, bne 000101, addi 001000, j 000010.
- Outputs are a Moore function of state, except `pcen` (also uses `zero`), `alucontrol` (also uses `funct`) and `illegal` (also uses `op`). Outputs not listed for a state are 0.
- FETCH: iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00, irwrite=1, pcwrite=1. Next state is DECODE.
- DECODE: alusrca=0, alusrcb=11, aluop=00. Next state depends on `op`:
  - lw or sw -> MEMADR
  - R-type -> RTYPEEX
  - beq or bne -> BREX
  - addi -> ADDIEX
  - j -> JEX
  - any other opcode -> FETCH with `illegal`=1. The instruction is treated as a nop.
- MEMADR: alusrca=1, alusrcb=10, aluop=00. Next is MEMRD for lw, MEMWR for sw.
- MEMRD: iord=1. Next is MEMWB.
- MEMWB: regdst=0, memtoreg=1, regwrite=1. Next is FETCH.
- MEMWR: iord=1, memwrite=1. Next is FETCH.
- RTYPEEX: alusrca=1, alusrcb=00, aluop=10. Next is RTYPEWB.
- RTYPEWB: regdst=1, memtoreg=0, regwrite=1. Next is FETCH.
- BREX: alusrca=1, alusrcb=00, aluop=01, pcsrc=01. The internal `beq`/`bne` qualifier comes from `op`. Next is FETCH.
- ADDIEX: alusrca=1, alusrcb=10, aluop=00. Next is ADDIWB.
- ADDIWB: regdst=0, memtoreg=0, regwrite=1. Next is FETCH.
- JEX: pcsrc=10, pcwrite=1. Next is FETCH.
- ALU decoder:
  - aluop 00 -> 010
  - aluop 01 -> 110
  - aluop 10 decodes `funct`: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111, any other funct -> 010
  - aluop 11 -> 010

## Timing
- Reset: asynchronous assertion puts the state in FETCH within the same cycle, so outputs immediately take FETCH values.
  - memwrite=0, regwrite=0, illegal=0, irwrite=1, pcen=1, alucontrol=010.
  - While `reset` is held, the FSM stays in FETCH. The PC and IR registers are held by their own reset.
  - Deassertion is sampled at the next rising edge; the first edge after release advances FETCH -> DECODE.
- Reset during any state abandons the instruction. No partial memwrite or regwrite is emitted after assertion.
- Cycles per instruction, FETCH inclusive: lw 5, sw 4, R-type 4, addi 4, beq/bne 3, j 3, illegal 2.
- `memwrite` and `regwrite` are each high for exactly one cycle per instruction that uses them.
- `pcen` in BREX follows `zero` combinationally in the same cycle. It is never asserted in BREX for any other opcode.
- Exactly one state per cycle; there are no wait states and no handshake.

## Structure
- Package `mc_pkg`:
  - `statetype_t` enum, 4 bits: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BREX, ADDIEX, ADDIWB, JEX
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J
  - funct constants and `alucontrol` encodings
  - 2-bit aluop encodings
- Sub-module `mc_aludec`: combinational, aluop + funct -> alucontrol.
- State register, next-state logic and output decode are in `multicycle_controller`.

## Test plan
- Reset held 3 cycles, released; op=100011 (lw) -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH. regwrite=1 and memtoreg=1 only in MEMWB; irwrite=1 only in FETCH.
- op=101011 (sw) -> memwrite=1 for exactly 1 cycle, in the 4th cycle, with iord=1; regwrite stays 0.
- op=000000, funct=101010 -> alucontrol=111 in RTYPEEX; regdst=1 and regwrite=1 in RTYPEWB; funct=111111 -> alucontrol=010.
- op=000100 with zero=1 -> pcen=1 and pcsrc=01 in BREX. op=000101 with zero=1 -> pcen=0. op=000101 with zero=0 -> pcen=1.
- op=000010 -> JEX with pcsrc=10 and pcen=1; back to FETCH after 3 cycles. op=111111 -> illegal=1 for 1 cycle in DECODE, then FETCH.
- Async reset asserted mid-cycle in MEMWR -> memwrite falls to 0 and irwrite rises before the next clock edge; after release the FSM restarts at FETCH.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit.
// Opcode/funct values match instr[31:26] and instr[5:0].
package mc_pkg;

  localparam int unsigned OP_W    = 6;
  localparam int unsigned FUNCT_W = 6;
  localparam int unsigned ALUOP_W = 2;
  localparam int unsigned ALUC_W  = 3;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BREX    = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11
  } statetype_t;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;

  localparam logic [FUNCT_W-1:0] FUNCT_ADD = 6'b100000;
  localparam logic [FUNCT_W-1:0] FUNCT_SUB = 6'b100010;
  localparam logic [FUNCT_W-1:0] FUNCT_AND = 6'b100100;
  localparam logic [FUNCT_W-1:0] FUNCT_OR  = 6'b100101;
  localparam logic [FUNCT_W-1:0] FUNCT_SLT = 6'b101010;

  localparam logic [ALUC_W-1:0] ALU_ADD = 3'b010;
  localparam logic [ALUC_W-1:0] ALU_SUB = 3'b110;
  localparam logic [ALUC_W-1:0] ALU_AND = 3'b000;
  localparam logic [ALUC_W-1:0] ALU_OR  = 3'b001;
  localparam logic [ALUC_W-1:0] ALU_SLT = 3'b111;

  localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
  localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
  localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/mc_aludec.sv
// Combinational ALU decoder: operation class plus funct field to ALU control.
module mc_aludec
  import mc_pkg::*;
(
  input  logic [ALUOP_W-1:0] aluop,
  input  logic [FUNCT_W-1:0] funct,
  output logic [ALUC_W-1:0]  alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FUNCT_ADD: alucontrol = ALU_ADD;
          FUNCT_SUB: alucontrol = ALU_SUB;
          FUNCT_AND: alucontrol = ALU_AND;
          FUNCT_OR:  alucontrol = ALU_OR;
          FUNCT_SLT: alucontrol = ALU_SLT;
          default:   alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS main control: Moore FSM sequencing fetch/decode/execute/mem/wb
// and driving datapath enables and mux selects.
module multicycle_controller
  import mc_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [OP_W-1:0]    op,
  input  logic [FUNCT_W-1:0] funct,
  input  logic               zero,
  output logic               iord,
  output logic               memwrite,
  output logic               irwrite,
  output logic               regdst,
  output logic               memtoreg,
  output logic               regwrite,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic [1:0]         pcsrc,
  output logic [ALUC_W-1:0]  alucontrol,
  output logic               pcen,
  output logic               illegal
);

  statetype_t           state, next_state;
  logic [ALUOP_W-1:0]   aluop;
  logic                 pcwrite;
  logic                 beq_en;
  logic                 bne_en;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    iord       = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    aluop      = ALUOP_ADD;
    pcwrite    = 1'b0;
    beq_en     = 1'b0;
    bne_en     = 1'b0;
    illegal    = 1'b0;
    case (state)
      FETCH: begin
        alusrcb    = 2'b01;
        irwrite    = 1'b1;
        pcwrite    = 1'b1;
        next_state = DECODE;
      end
      DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW:    next_state = MEMADR;
          OP_RTYPE:        next_state = RTYPEEX;
          OP_BEQ, OP_BNE:  next_state = BREX;
          OP_ADDI:         next_state = ADDIEX;
          OP_J:            next_state = JEX;
          default: begin
            next_state = FETCH;
            illegal    = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        next_state = (op == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        iord       = 1'b1;
        next_state = MEMWB;
      end
      MEMWB: begin
        memtoreg   = 1'b1;
        regwrite   = 1'b1;
        next_state = FETCH;
      end
      MEMWR: begin
        iord       = 1'b1;
        memwrite   = 1'b1;
        next_state = FETCH;
      end
      RTYPEEX: begin
        alusrca    = 1'b1;
        aluop      = ALUOP_FUNCT;
        next_state = RTYPEWB;
      end
      RTYPEWB: begin
        regdst     = 1'b1;
        regwrite   = 1'b1;
        next_state = FETCH;
      end
      BREX: begin
        alusrca    = 1'b1;
        aluop      = ALUOP_SUB;
        pcsrc      = 2'b01;
        beq_en     = (op == OP_BEQ);
        bne_en     = (op == OP_BNE);
        next_state = FETCH;
      end
      ADDIEX: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        next_state = ADDIWB;
      end
      ADDIWB: begin
        regwrite   = 1'b1;
        next_state = FETCH;
      end
      JEX: begin
        pcsrc      = 2'b10;
        pcwrite    = 1'b1;
        next_state = FETCH;
      end
      default: next_state = FETCH;
    endcase
  end

  // Branch qualifiers only exist in BREX, so pcen tracks zero there and nowhere else.
  assign pcen = pcwrite | (beq_en & zero) | (bne_en & ~zero);

  mc_aludec u_aludec (
    .aluop      (aluop),
    .funct      (funct),
    .alucontrol (alucontrol)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: directed instructions push
// per-cycle expected output vectors; a negedge monitor pops and compares.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] op = 6'b100011;
  logic [5:0] funct = 6'b000000;
  logic       zero = 1'b0;
  logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic       pcen, illegal;

  int tests = 0;
  int fails = 0;

  typedef struct {
    string       name;
    logic [15:0] v;
  } exp_t;

  exp_t sb[$];

  multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .regdst(regdst),
    .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol),
    .pcen(pcen), .illegal(illegal)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mk(input logic i_iord, i_mw, i_irw, i_rd, i_m2r, i_rw,
                                     i_asa, input logic [1:0] i_asb, i_pcs,
                                     input logic [2:0] i_ac, input logic i_pcen, i_ill);
    return {i_iord, i_mw, i_irw, i_rd, i_m2r, i_rw, i_asa, i_asb, i_pcs, i_ac, i_pcen, i_ill};
  endfunction

  // Hand-derived per-state output vectors
  localparam logic [15:0] V_FETCH   = 16'b0_0_1_0_0_0_0_01_00_010_1_0;
  localparam logic [15:0] V_DECODE  = 16'b0_0_0_0_0_0_0_11_00_010_0_0;
  localparam logic [15:0] V_DEC_ILL = 16'b0_0_0_0_0_0_0_11_00_010_0_1;
  localparam logic [15:0] V_MEMADR  = 16'b0_0_0_0_0_0_1_10_00_010_0_0;
  localparam logic [15:0] V_MEMRD   = 16'b1_0_0_0_0_0_0_00_00_010_0_0;
  localparam logic [15:0] V_MEMWB   = 16'b0_0_0_0_1_1_0_00_00_010_0_0;
  localparam logic [15:0] V_MEMWR   = 16'b1_1_0_0_0_0_0_00_00_010_0_0;
  localparam logic [15:0] V_RTWB    = 16'b0_0_0_1_0_1_0_00_00_010_0_0;
  localparam logic [15:0] V_ADDIEX  = 16'b0_0_0_0_0_0_1_10_00_010_0_0;
  localparam logic [15:0] V_ADDIWB  = 16'b0_0_0_0_0_1_0_00_00_010_0_0;
  localparam logic [15:0] V_JEX     = 16'b0_0_0_0_0_0_0_00_10_010_1_0;

  function automatic logic [15:0] actual();
    return mk(iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
              alusrcb, pcsrc, alucontrol, pcen, illegal);
  endfunction

  task automatic push(input string name, input logic [15:0] v);
    exp_t e;
    e.name = name;
    e.v    = v;
    sb.push_back(e);
  endtask

  task automatic check_now(input string name, input logic [15:0] v);
    logic [15:0] a;
    a = actual();
    tests++;
    if (a !== v) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, a, v);
    end
  endtask

  task automatic next_instr(input logic [5:0] o, input logic [5:0] f, input logic z);
    @(posedge clk);
    #1;
    op = o; funct = f; zero = z;
  endtask

  // Monitor: every cycle with a pending expectation is compared at the falling edge
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic [15:0] a;
      e = sb.pop_front();
      a = actual();
      tests++;
      if (a !== e.v) begin
        fails++;
        $display("FAIL %s: got %b expected %b", e.name, a, e.v);
      end
    end
  end

  initial begin
    // Reset held; outputs must show FETCH values
    repeat (2) @(posedge clk);
    #1 check_now("reset_fetch", V_FETCH);
    @(posedge clk);
    #1 reset = 1'b0;
    push("lw_fetch", V_FETCH); push("lw_decode", V_DECODE); push("lw_memadr", V_MEMADR);
    push("lw_memrd", V_MEMRD); push("lw_memwb", V_MEMWB);
    repeat (4) @(posedge clk);

    next_instr(6'b101011, 6'b000000, 1'b0);
    push("sw_fetch", V_FETCH); push("sw_decode", V_DECODE); push("sw_memadr", V_MEMADR);
    push("sw_memwr", V_MEMWR);
    repeat (3) @(posedge clk);

    next_instr(6'b000000, 6'b101010, 1'b0);
    push("slt_fetch", V_FETCH); push("slt_decode", V_DECODE);
    push("slt_ex", mk(0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 3'b111, 0, 0));
    push("slt_wb", V_RTWB);
    repeat (3) @(posedge clk);

    next_instr(6'b000000, 6'b111111, 1'b0);
    push("badfn_fetch", V_FETCH); push("badfn_decode", V_DECODE);
    push("badfn_ex", mk(0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 3'b010, 0, 0));
    push("badfn_wb", V_RTWB);
    repeat (3) @(posedge clk);

    next_instr(6'b000000, 6'b100010, 1'b1);
    push("sub_fetch", V_FETCH); push("sub_decode", V_DECODE);
    push("sub_ex", mk(0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 3'b110, 0, 0));
    push("sub_wb", V_RTWB);
    repeat (3) @(posedge clk);

    next_instr(6'b000100, 6'b000000, 1'b1);
    push("beq_z1_fetch", V_FETCH); push("beq_z1_decode", V_DECODE);
    push("beq_z1_brex", mk(0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 3'b110, 1, 0));
    repeat (2) @(posedge clk);

    next_instr(6'b000100, 6'b000000, 1'b0);
    push("beq_z0_fetch", V_FETCH); push("beq_z0_decode", V_DECODE);
    push("beq_z0_brex", mk(0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 3'b110, 0, 0));
    repeat (2) @(posedge clk);

    next_instr(6'b000101, 6'b000000, 1'b1);
    push("bne_z1_fetch", V_FETCH); push("bne_z1_decode", V_DECODE);
    push("bne_z1_brex", mk(0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 3'b110, 0, 0));
    repeat (2) @(posedge clk);

    next_instr(6'b000101, 6'b000000, 1'b0);
    push("bne_z0_fetch", V_FETCH); push("bne_z0_decode", V_DECODE);
    push("bne_z0_brex", mk(0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 3'b110, 1, 0));
    repeat (2) @(posedge clk);

    next_instr(6'b001000, 6'b000000, 1'b0);
    push("addi_fetch", V_FETCH); push("addi_decode", V_DECODE);
    push("addi_ex", V_ADDIEX); push("addi_wb", V_ADDIWB);
    repeat (3) @(posedge clk);

    next_instr(6'b000010, 6'b000000, 1'b0);
    push("j_fetch", V_FETCH); push("j_decode", V_DECODE); push("j_jex", V_JEX);
    repeat (2) @(posedge clk);

    next_instr(6'b111111, 6'b000000, 1'b0);
    push("ill_fetch", V_FETCH); push("ill_decode", V_DEC_ILL);
    @(posedge clk);

    // sw, then async reset in the middle of MEMWR
    next_instr(6'b101011, 6'b000000, 1'b0);
    push("sw2_fetch", V_FETCH); push("sw2_decode", V_DECODE); push("sw2_memadr", V_MEMADR);
    push("sw2_memwr", V_MEMWR);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1 check_now("async_reset_memwr", V_FETCH);
    @(posedge clk);
    #1 check_now("reset_hold", V_FETCH);
    @(posedge clk);
    #1 reset = 1'b0;
    op = 6'b000010; funct = 6'b000000; zero = 1'b0;
    push("post_rst_fetch", V_FETCH); push("post_rst_decode", V_DECODE);
    push("post_rst_jex", V_JEX);
    repeat (2) @(posedge clk);

    // Back in FETCH after the jump
    next_instr(6'b000010, 6'b000000, 1'b0);
    push("final_fetch", V_FETCH);
    @(negedge clk);
    #1;
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
